stack: RTL and testbench

Synchronous LIFO stack of 32-bit words for the MIPS datapath. It exposes the top two entries combinationally, so an operand-pair consumer can read both at once. One push or pop is applied per clock. Overflow and underflow are silently ignored, and status flags are provided.

---
 rtl/stack_if.sv | 26 ++
 rtl/stack.sv | 87 ++++++++
 tb/tb_stack.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/stack_if.sv
// Operand-stack bus: push/pop requests in, top-two entries and status flags out.
interface stack_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out_1st;
  logic [WIDTH-1:0] data_out_2nd;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;

  modport master (
    output push, pop, data_in,
    input  data_out_1st, data_out_2nd, count, empty, full
  );

  modport slave (
    input  push, pop, data_in,
    output data_out_1st, data_out_2nd, count, empty, full
  );
endinterface

// File: rtl/stack.sv
// LIFO word stack exposing the top two entries combinationally.
// One push, pop or replace-top per clock; overflow/underflow are ignored.

// One storage word with write enable and async clear.
module stack_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Capture the write data when this slot is addressed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic   clock,
  input  logic   reset,
  stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  logic [CW-1:0]                sp;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic [DEPTH-1:0]             we;
  logic                         is_empty, is_full;
  logic                         do_push, do_pop, do_repl;
  logic [CW-1:0]                sp_m1, sp_m2;
  logic [IW-1:0]                wr_idx, top_idx, sec_idx;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == FULL_CNT);

  // push+pop on an empty stack degenerates to a plain push; otherwise it
  // overwrites the top in place. Empty is never full since DEPTH >= 2.
  assign do_push = bus.push & (~bus.pop | is_empty) & ~is_full;
  assign do_pop  = bus.pop  & ~bus.push & ~is_empty;
  assign do_repl = bus.push & bus.pop   & ~is_empty;

  assign sp_m1   = sp - ONE;
  assign sp_m2   = sp - TWO;
  assign top_idx = sp_m1[IW-1:0];
  assign sec_idx = sp_m2[IW-1:0];
  assign wr_idx  = do_repl ? sp_m1[IW-1:0] : sp[IW-1:0];

  // One-hot write enable for the addressed slot.
  always_comb begin
    we = '0;
    if (do_push | do_repl) we[wr_idx] = 1'b1;
  end

  // Storage cells; popped entries keep stale data but are masked below.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    stack_cell #(.WIDTH(WIDTH)) u_cell (
      .clock (clock),
      .reset (reset),
      .we    (we[g]),
      .d     (bus.data_in),
      .q     (mem[g])
    );
  end

  // Stack pointer: next free slot, saturating via the ignore rules.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       sp <= '0;
    else if (do_push) sp <= sp + ONE;
    else if (do_pop)  sp <= sp_m1;
  end

  assign bus.data_out_1st = (sp >= ONE) ? mem[top_idx] : '0;
  assign bus.data_out_2nd = (sp >= TWO) ? mem[sec_idx] : '0;
  assign bus.count        = sp;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
endmodule

// File: tb/tb_stack.sv
// Bench for stack: directed test-plan sequences plus random push/pop traffic
// checked against a queue-based LIFO model.
module tb_stack;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;

  stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Compare every output against the queue model.
  task automatic check_model(input string tag);
    logic [WIDTH-1:0] e1, e2;
    int n;
    n  = q.size();
    e1 = (n >= 1) ? q[n-1] : '0;
    e2 = (n >= 2) ? q[n-2] : '0;
    chk({tag, "_1st"},   64'(bus.data_out_1st), 64'(e1));
    chk({tag, "_2nd"},   64'(bus.data_out_2nd), 64'(e2));
    chk({tag, "_count"}, 64'(bus.count),        64'(n));
    chk({tag, "_empty"}, 64'(bus.empty),        64'(n == 0));
    chk({tag, "_full"},  64'(bus.full),         64'(n == DEPTH));
  endtask

  // Apply one request for one clock, step the model, check after the edge.
  task automatic op(input logic p, input logic o, input logic [WIDTH-1:0] d, input string tag);
    bus.push    = p;
    bus.pop     = o;
    bus.data_in = d;
    @(posedge clock);
    if (p && o) begin
      if (q.size() == 0) q.push_back(d);
      else               q[q.size()-1] = d;
    end else if (p) begin
      if (q.size() < DEPTH) q.push_back(d);
    end else if (o) begin
      if (q.size() > 0) void'(q.pop_back());
    end
    @(negedge clock);
    check_model(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] words [4];
    logic [WIDTH-1:0] pop_top [5];
    logic [WIDTH-1:0] pop_sec [5];
    words   = '{32'hAAAA_0000, 32'hBBBB_0000, 32'hCCCC_0000, 32'hDDDD_0000};
    pop_top = '{32'hCCCC_0000, 32'hBBBB_0000, 32'hAAAA_0000, 32'h0, 32'h0};
    pop_sec = '{32'hBBBB_0000, 32'hAAAA_0000, 32'h0, 32'h0, 32'h0};

    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;

    // Reset held while clock toggles, with requests active.
    bus.push = 1'b1; bus.data_in = 32'hFFFF_FFFF;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_1st",   64'(bus.data_out_1st), 64'h0);
    chk("rst_2nd",   64'(bus.data_out_2nd), 64'h0);
    chk("rst_count", 64'(bus.count),        64'h0);
    chk("rst_empty", 64'(bus.empty),        64'h1);
    chk("rst_full",  64'(bus.full),         64'h0);
    bus.push = 1'b0;
    reset = 1'b1;

    // Push sequence.
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 1'b0, words[i], "push");
      chk("push_top", 64'(bus.data_out_1st), 64'(words[i]));
      if (i > 0) chk("push_sec", 64'(bus.data_out_2nd), 64'(words[i-1]));
    end
    chk("push_cnt", 64'(bus.count), 64'd4);

    // Idle.
    for (int i = 0; i < 3; i++) op(1'b0, 1'b0, 32'h1111_1111, "idle");
    chk("idle_top", 64'(bus.data_out_1st), 64'hDDDD_0000);
    chk("idle_sec", 64'(bus.data_out_2nd), 64'hCCCC_0000);

    // Pop sequence, fifth one underflows.
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 1'b1, 32'h0, "pop");
      chk("pop_top", 64'(bus.data_out_1st), 64'(pop_top[i]));
      chk("pop_sec", 64'(bus.data_out_2nd), 64'(pop_sec[i]));
      chk("pop_cnt", 64'(bus.count),        64'((i < 4) ? 3 - i : 0));
    end
    chk("pop_empty", 64'(bus.empty), 64'h1);

    // Overflow.
    for (int i = 0; i < DEPTH + 2; i++) begin
      op(1'b1, 1'b0, 32'h0100_0000 + 32'(i), "ovf");
      if (i == DEPTH - 1) chk("ovf_full_at_depth", 64'(bus.full), 64'h1);
    end
    chk("ovf_top",  64'(bus.data_out_1st), 64'(32'h0100_0000 + 32'(DEPTH - 1)));
    chk("ovf_cnt",  64'(bus.count),        64'(DEPTH));

    // Asynchronous reset between edges.
    bus.push = 1'b0; bus.pop = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_count", 64'(bus.count),        64'h0);
    chk("arst_1st",   64'(bus.data_out_1st), 64'h0);
    chk("arst_empty", 64'(bus.empty),        64'h1);
    q.delete();
    @(negedge clock);
    reset = 1'b1;

    // Replace-top with two entries.
    op(1'b1, 1'b0, 32'hA0A0_A0A0, "rep_a");
    op(1'b1, 1'b0, 32'hB0B0_B0B0, "rep_b");
    op(1'b1, 1'b1, 32'h1234_5678, "rep");
    chk("rep_top", 64'(bus.data_out_1st), 64'h1234_5678);
    chk("rep_sec", 64'(bus.data_out_2nd), 64'hA0A0_A0A0);
    chk("rep_cnt", 64'(bus.count),        64'd2);

    // Push+pop on empty acts as push.
    op(1'b0, 1'b1, 32'h0, "drain");
    op(1'b0, 1'b1, 32'h0, "drain");
    op(1'b1, 1'b1, 32'h55, "pp_empty");
    chk("pp_empty_cnt", 64'(bus.count),        64'd1);
    chk("pp_empty_top", 64'(bus.data_out_1st), 64'h55);

    // Random traffic, alternating push-heavy and pop-heavy phases so both
    // full and empty boundaries are exercised.
    for (int k = 0; k < 600; k++) begin
      int r;
      logic p, o;
      r = int'($urandom_range(0, 99));
      if (((k / 40) % 2) == 0) begin
        p = (r < 60) || (r >= 90);
        o = (r >= 60) && (r < 75) || (r >= 90);
      end else begin
        p = (r < 15) || (r >= 90);
        o = (r >= 15) && (r < 75) || (r >= 90);
      end
      op(p, o, $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
